// File: rtl/ysyx_22041207_sext.sv
// rtl/ysyx_22041207_sext.sv - RV64 format classifier and immediate generator.
// Optional macro SEXT_SHAMT_ZEXT_EN: shift-immediates yield a zero-extended shamt.
module ysyx_22041207_sext #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    output logic [2:0]      inst_type,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      type_q,
    output logic [XLEN-1:0] imm_q,
    output logic            valid_q
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_sign;
    fmt_e        w_fmt;
    logic [63:0] w_imm;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_sign   = inst[31];

    always_comb begin
        w_fmt = FMT_NONE;
        unique case (w_opcode)
            7'b0110011, 7'b0111011:                       w_fmt = FMT_R;
            7'b0010011, 7'b0011011, 7'b0000011,
            7'b1100111, 7'b1110011:                       w_fmt = FMT_I;
            7'b0100011:                                   w_fmt = FMT_S;
            7'b1100011:                                   w_fmt = FMT_B;
            7'b0110111, 7'b0010111:                       w_fmt = FMT_U;
            7'b1101111:                                   w_fmt = FMT_J;
            default:                                      w_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        w_imm = 64'd0;
        case (w_fmt)
            FMT_I: w_imm = {{52{w_sign}}, inst[31:20]};
            FMT_S: w_imm = {{52{w_sign}}, inst[31:25], inst[11:7]};
            FMT_B: w_imm = {{52{w_sign}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: w_imm = {{32{w_sign}}, inst[31:12], 12'b0};
            FMT_J: w_imm = {{44{w_sign}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: w_imm = 64'd0;
        endcase
`ifdef SEXT_SHAMT_ZEXT_EN
        // Shift-immediates: drop funct7/funct6 so decode sees the bare shamt.
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            if (w_opcode == 7'b0010011)
                w_imm = {58'd0, inst[25:20]};
            else if (w_opcode == 7'b0011011)
                w_imm = {59'd0, inst[24:20]};
        end
`endif
    end

    assign inst_type = w_fmt;
    assign imm       = w_imm[XLEN-1:0];

    logic [2:0]      r_type;
    logic [XLEN-1:0] r_imm;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_type  <= FMT_NONE;
            r_imm   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= inst_valid;
            if (inst_valid) begin
                r_type <= inst_type;
                r_imm  <= imm;
            end
        end
    end

    assign type_q  = r_type;
    assign imm_q   = r_imm;
    assign valid_q = r_valid;

`ifndef SEXT_SHAMT_ZEXT_EN
    logic w_unused;
    assign w_unused = ^w_funct3;
`endif

endmodule

// File: tb/tb_ysyx_22041207_sext.sv
// tb/tb_ysyx_22041207_sext.sv - self-checking bench for ysyx_22041207_sext.
module tb_ysyx_22041207_sext;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic [2:0]  inst_type;
    logic [63:0] imm;
    logic [2:0]  type_q;
    logic [63:0] imm_q;
    logic        valid_q;

    int n_vec = 0;
    int n_bad = 0;

    logic [2:0]  e_type_q;
    logic [63:0] e_imm_q;
    logic        e_valid_q;

    ysyx_22041207_sext #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .inst_valid(inst_valid),
        .inst_type (inst_type),
        .imm       (imm),
        .type_q    (type_q),
        .imm_q     (imm_q),
        .valid_q   (valid_q)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_type(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op inside {7'h33, 7'h3B}) return 3'd0;
        if (op inside {7'h13, 7'h1B, 7'h03, 7'h67, 7'h73}) return 3'd1;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h63) return 3'd3;
        if (op inside {7'h37, 7'h17}) return 3'd4;
        if (op == 7'h6F) return 3'd5;
        return 3'd7;
    endfunction

    // Arithmetic view: sign-extend the word, shift down, then OR in the scattered fields.
    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint s, t;
        longint u;
        logic [2:0] f3;
        s = $signed(i);
        u = longint'({32'd0, i});
        f3 = i[14:12];
`ifdef SEXT_SHAMT_ZEXT_EN
        if (i[6:0] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return (u >> 20) & 63;
        if (i[6:0] == 7'h1B && (f3 == 3'd1 || f3 == 3'd5)) return (u >> 20) & 31;
`endif
        case (ref_type(i))
            3'd1: begin t = s >>> 20; return t; end
            3'd2: begin t = s >>> 25; return (t * 32) + ((u >> 7) & 31); end
            3'd3: begin
                t = s >>> 31;
                return (t * 4096) + (((u >> 7) & 1) * 2048)
                     + (((u >> 25) & 63) * 32) + (((u >> 8) & 15) * 2);
            end
            3'd4: begin t = s >>> 12; return t * 4096; end
            3'd5: begin
                t = s >>> 31;
                return (t * 1048576) + (((u >> 12) & 255) * 4096)
                     + (((u >> 20) & 1) * 2048) + (((u >> 21) & 1023) * 2);
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk3(input string tag, input logic [2:0] o, input logic [2:0] e);
        n_vec++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drive at negedge, check combinational path, clock once, check registered path.
    task automatic apply(input logic [31:0] i, input logic v, input logic r);
        @(negedge clk);
        inst = i; inst_valid = v; rst = r;
        #1;
        chk3("inst_type", inst_type, ref_type(i));
        chk64("imm", imm, ref_imm(i));
        if (r) begin
            e_type_q = 3'd7; e_imm_q = 64'd0; e_valid_q = 1'b0;
        end else begin
            e_valid_q = v;
            if (v) begin
                e_type_q = ref_type(i); e_imm_q = ref_imm(i);
            end
        end
        @(posedge clk);
        #1;
        chk3("type_q", type_q, e_type_q);
        chk64("imm_q", imm_q, e_imm_q);
        chk3("valid_q", {2'b0, valid_q}, {2'b0, e_valid_q});
    endtask

    task automatic expect_now(input string tag, input logic [2:0] t, input logic [63:0] m);
        chk3({tag, ".type"}, inst_type, t);
        chk64({tag, ".imm"}, imm, m);
    endtask

    logic [6:0] ops [12] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67,
                            7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        logic [31:0] w;
        rst = 1'b1; inst = 32'd0; inst_valid = 1'b0;
        e_type_q = 3'd7; e_imm_q = 64'd0; e_valid_q = 1'b0;

        apply(32'hFFF00093, 1'b1, 1'b1);
        apply(32'hFFF00093, 1'b1, 1'b1);
        chk3("reset.type_q", type_q, 3'd7);
        chk64("reset.imm_q", imm_q, 64'd0);

        apply(32'hFFF00093, 1'b0, 1'b0); expect_now("addi", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        apply(32'h0020B423, 1'b0, 1'b0); expect_now("sd",   3'd2, 64'h8);
        apply(32'hFE000EE3, 1'b0, 1'b0); expect_now("beq",  3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
        apply(32'h800000B7, 1'b0, 1'b0); expect_now("lui",  3'd4, 64'hFFFF_FFFF_8000_0000);
        apply(32'h30200073, 1'b0, 1'b0); expect_now("mret", 3'd1, 64'h302);
        apply(32'h00000073, 1'b0, 1'b0); expect_now("ecall", 3'd1, 64'h0);
        apply(32'h00100073, 1'b0, 1'b0); expect_now("ebreak", 3'd1, 64'h1);
        apply(32'h0000007F, 1'b0, 1'b0); expect_now("none", 3'd7, 64'h0);
        apply(32'h00B50533, 1'b0, 1'b0); expect_now("add",  3'd0, 64'h0);
`ifndef SEXT_SHAMT_ZEXT_EN
        apply(32'h4030D093, 1'b0, 1'b0); expect_now("srai", 3'd1, 64'h403);
`else
        apply(32'h4030D093, 1'b0, 1'b0); expect_now("srai", 3'd1, 64'h3);
`endif
        apply(32'h001000EF, 1'b1, 1'b0); expect_now("jal", 3'd5, 64'h800);
        chk3("jal.type_q", type_q, 3'd5);
        chk64("jal.imm_q", imm_q, 64'h800);
        chk3("jal.valid_q", {2'b0, valid_q}, 3'd1);
        apply(32'h800000B7, 1'b0, 1'b0);
        chk3("hold.type_q", type_q, 3'd5);
        chk64("hold.imm_q", imm_q, 64'h800);
        chk3("hold.valid_q", {2'b0, valid_q}, 3'd0);
        apply(32'h800000B7, 1'b1, 1'b1);
        chk3("rstwins.type_q", type_q, 3'd7);

        for (int k = 0; k < 400; k++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 11)];
            apply(w, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
